// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: display mode sequencer, time/alarm counter enables and alarm ring control.
// Build option: define SNOOZE_EN to include the snooze state and its minute counter.
//
// Mode FSM
//   state        | meaning
//   M_RUN        | clock runs, alarm may trigger
//   M_SET_TIME   | seconds frozen, min/hrs advanced by the buttons
//   M_SET_ALARM  | display shows alarm, alarm min/hrs advanced by the buttons
//
// Alarm FSM
//   state        | meaning
//   A_IDLE       | silent, waiting for a rising alarm match in RUN
//   A_RING       | buzzer on, ring timer counting ticks
//   A_SNOOZE     | buzzer off, waiting SNOOZE_MIN minute rollovers (SNOOZE_EN only)
module clock_mode_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       min_adv,
    input  logic       hrs_adv,
    input  logic       alarm_on,
    input  logic       snooze_btn,
    input  logic       alarm_match,
    input  logic       s_max,
    input  logic       m_max,
    output logic       sec_en,
    output logic       min_en,
    output logic       hrs_en,
    output logic       amin_en,
    output logic       ahrs_en,
    output logic       disp_alarm,
    output logic [1:0] mode,
    output logic       buzz
);

    typedef enum logic [1:0] {
        M_RUN       = 2'd0,
        M_SET_TIME  = 2'd1,
        M_SET_ALARM = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_RING   = 2'd1,
        A_SNOOZE = 2'd2
    } alarm_t;

    localparam logic [7:0] RING_LOAD = 8'(RING_SEC);

    mode_t      mode_q, mode_d;
    alarm_t     alarm_q, alarm_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       mode_btn_q, match_q;
    logic       mode_rise, match_rise;
    logic       set_time, set_alarm;
    logic       sec_en_d, min_en_d, hrs_en_d, amin_en_d, ahrs_en_d;

`ifdef SNOOZE_EN
    localparam logic [3:0] SNZ_LOAD = 4'(SNOOZE_MIN);
    logic [3:0] snz_cnt_q, snz_cnt_d;
    logic       snooze_btn_q, snooze_rise;
    assign snooze_rise = snooze_btn & ~snooze_btn_q;
`else
    logic unused_snooze_btn;
    assign unused_snooze_btn = snooze_btn;
`endif

    assign mode_rise  = mode_btn & ~mode_btn_q;
    assign match_rise = alarm_match & ~match_q;
    assign set_time   = (mode_q == M_SET_TIME);
    assign set_alarm  = (mode_q == M_SET_ALARM);
    assign mode       = mode_q;

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            M_RUN:       if (mode_rise) mode_d = M_SET_TIME;
            M_SET_TIME:  if (mode_rise) mode_d = M_SET_ALARM;
            M_SET_ALARM: if (mode_rise) mode_d = M_RUN;
            default:     mode_d = M_RUN;
        endcase
    end

    // Enables use the mode in force on the tick cycle; carries pass straight through.
    always_comb begin
        sec_en_d  = tick & ~set_time;
        min_en_d  = tick & (set_time ? min_adv : s_max);
        hrs_en_d  = tick & (set_time ? hrs_adv : (s_max & m_max));
        amin_en_d = tick & set_alarm & min_adv;
        ahrs_en_d = tick & set_alarm & hrs_adv;
    end

    // Ring timer counts remaining ring ticks down; exit on the tick that sees 1.
    always_comb begin
        alarm_d    = alarm_q;
        ring_cnt_d = ring_cnt_q;
`ifdef SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        case (alarm_q)
            A_IDLE: begin
                if ((mode_q == M_RUN) && alarm_on && match_rise) begin
                    alarm_d    = A_RING;
                    ring_cnt_d = RING_LOAD;
                end
            end
            A_RING: begin
                if (mode_rise || !alarm_on) begin
                    alarm_d = A_IDLE;
                end else if (tick && (ring_cnt_q == 8'd1)) begin
                    alarm_d = A_IDLE;
`ifdef SNOOZE_EN
                end else if (snooze_rise) begin
                    alarm_d   = A_SNOOZE;
                    snz_cnt_d = SNZ_LOAD;
`endif
                end else if (tick) begin
                    ring_cnt_d = ring_cnt_q - 8'd1;
                end
            end
`ifdef SNOOZE_EN
            A_SNOOZE: begin
                if (mode_rise || !alarm_on) begin
                    alarm_d = A_IDLE;
                end else if (tick && s_max) begin
                    if (snz_cnt_q == 4'd1) begin
                        alarm_d    = A_RING;
                        ring_cnt_d = RING_LOAD;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 4'd1;
                    end
                end
            end
`endif
            default: alarm_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= M_RUN;
            alarm_q      <= A_IDLE;
            ring_cnt_q   <= 8'd0;
            mode_btn_q   <= 1'b0;
            match_q      <= 1'b0;
            sec_en       <= 1'b0;
            min_en       <= 1'b0;
            hrs_en       <= 1'b0;
            amin_en      <= 1'b0;
            ahrs_en      <= 1'b0;
            disp_alarm   <= 1'b0;
            buzz         <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            alarm_q      <= alarm_d;
            ring_cnt_q   <= ring_cnt_d;
            mode_btn_q   <= mode_btn;
            match_q      <= alarm_match;
            sec_en       <= sec_en_d;
            min_en       <= min_en_d;
            hrs_en       <= hrs_en_d;
            amin_en      <= amin_en_d;
            ahrs_en      <= ahrs_en_d;
            disp_alarm   <= (mode_d == M_SET_ALARM);
            buzz         <= (alarm_d == A_RING);
        end
    end

`ifdef SNOOZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snz_cnt_q    <= 4'd0;
            snooze_btn_q <= 1'b0;
        end else begin
            snz_cnt_q    <= snz_cnt_d;
            snooze_btn_q <= snooze_btn;
        end
    end
`endif

endmodule
